fb_fill_engine: RTL and testbench

Rectangle-fill command engine sitting directly upstream of `pspi_host` in the framebuffer path. Accepts one fill command (origin, size, RGB565 colour), clips it to the screen and walks it row-major, issuing one 32-bit PSPI write per pixel pair with the host's pulse/ready handshake. Reports completion with a single-cycle `done` pulse, so top-level logic (cursor painter, clear-screen button) can draw regions without sequencing individual pixel writes.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_addr_gen.sv | 68 ++++++
 rtl/fb_fill_engine.sv | 130 +++++++++++++
 tb/tb_fb_fill_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: screen geometry, RGB565 colours,
// fill-engine state encoding and the host byte-order helper.
package fb_pkg;

    localparam int unsigned FB_H_RES = 320;
    localparam int unsigned FB_V_RES = 240;

    // RGB565 colours in natural bit order
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLACK  = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } fb_state_e;

    // The PSPI host expects each pixel byte-swapped
    function automatic logic [15:0] rgb565_swap(input logic [15:0] c);
        return {c[7:0], c[15:8]};
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Row-major pixel-pair address walker for fb_fill_engine. Holds the
// column, row and row base address; loads on accept, steps one word
// per completed write and flags the final word of the rectangle.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int unsigned H_RES   = FB_H_RES,
    parameter logic [31:0] FB_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [16:0] x0,
    input  logic [16:0] x1,
    input  logic [16:0] y0,
    input  logic [16:0] y1,
    output logic [31:0] addr,
    output logic        last
);

    localparam logic [31:0] ROW_BYTES = 32'(H_RES * 2);

    logic [16:0] col;
    logic [16:0] row;
    logic [31:0] row_base;
    logic [16:0] x0_q;
    logic [16:0] x1_q;
    logic [16:0] y1_q;
    logic [16:0] col_nxt;
    logic        row_end;

    // Next column, row wrap detection, final-word flag and byte address
    always_comb begin
        col_nxt = col + 17'd2;
        row_end = (col_nxt == x1_q);
        last    = row_end && ((row + 17'd1) == y1_q);
        addr    = row_base + {14'd0, col, 1'b0};
    end

    // Counters: the only multiply happens once at load, stepping is adders only
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
        end else if (load) begin
            col      <= x0;
            row      <= y0;
            row_base <= FB_BASE + 32'(y0) * ROW_BYTES;
            x0_q     <= x0;
            x1_q     <= x1;
            y1_q     <= y1;
        end else if (step) begin
            if (row_end) begin
                col      <= x0_q;
                row      <= row + 17'd1;
                row_base <= row_base + ROW_BYTES;
            end else begin
                col <= col_nxt;
            end
        end
    end

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill command engine feeding pspi_host. Accepts one fill
// command, walks it row-major issuing one 32-bit write per pixel pair,
// and pulses done when finished.
// Optional macro FB_FILL_CLIP_EN: clip the rectangle to the screen;
// without it extents are used as given and addresses wrap freely.
module fb_fill_engine
    import fb_pkg::*;
#(
    parameter int unsigned H_RES   = 320,
    parameter int unsigned V_RES   = 240,
    parameter logic [31:0] FB_BASE = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [15:0] cmd_w,
    input  logic [15:0] cmd_h,
    input  logic [15:0] cmd_color,
    output logic        done,
    output logic [31:0] pspi_a,
    output logic [31:0] pspi_d,
    output logic        pspi_we,
    input  logic        pspi_ready
);

    // Clipping relies on an even width so the column walk lands exactly on x1
    if (H_RES == 0 || (H_RES % 2) != 0 || V_RES == 0) begin : g_bad_geometry
        $error("fb_fill_engine: screen geometry must be non-zero with even width");
    end

    fb_state_e   state;
    fb_state_e   state_nxt;
    logic [15:0] color_q;
    logic        load;
    logic        step;
    logic        last;
    logic        empty;
    logic [16:0] x0;
    logic [16:0] w_even;
    logic [16:0] x1;
    logic [16:0] y0;
    logic [16:0] y1;

    // Rectangle extent from the offered command (17 bits so unclipped sums never overflow)
    always_comb begin
        x0     = {1'b0, cmd_x[15:1], 1'b0};
        w_even = ({1'b0, cmd_w} + 17'd1) & ~17'd1;
        y0     = {1'b0, cmd_y};
        x1     = x0 + w_even;
        y1     = y0 + {1'b0, cmd_h};
`ifdef FB_FILL_CLIP_EN
        if (x1 > 17'(H_RES)) x1 = 17'(H_RES);
        if (y1 > 17'(V_RES)) y1 = 17'(V_RES);
        empty = (x0 >= 17'(H_RES)) || (y0 >= 17'(V_RES)) || (x1 <= x0) || (y1 <= y0);
`else
        empty = (x1 <= x0) || (y1 <= y0);
`endif
    end

    fb_addr_gen #(
        .H_RES   (H_RES),
        .FB_BASE (FB_BASE)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .x0   (x0),
        .x1   (x1),
        .y0   (y0),
        .y1   (y1),
        .addr (pspi_a),
        .last (last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Colour is captured at accept so later cmd_color changes are ignored
    always_ff @(posedge clk) begin
        if (rst)       color_q <= BLACK;
        else if (load) color_q <= cmd_color;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        cmd_ready = 1'b0;
        pspi_we   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load      = 1'b1;
                    state_nxt = empty ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pspi_we   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (pspi_ready) begin
                    step      = 1'b1;
                    state_nxt = last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write data: the same byte-swapped pixel in both halves of the word
    always_comb begin
        pspi_d = {rgb565_swap(color_q), rgb565_swap(color_q)};
    end

endmodule

// File: tb/tb_fb_fill_engine.sv
// Scoreboard bench for fb_fill_engine: a reference model expands each
// command into its expected write list plus a done marker; a monitor
// pops and compares whenever the DUT writes or signals done.
`timescale 1ns/1ps
module tb_fb_fill_engine;
    import fb_pkg::*;

    localparam int unsigned H = 320;
    localparam int unsigned V = 240;
    localparam logic [31:0] BASE = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0, cmd_color = '0;
    logic        done;
    logic [31:0] pspi_a, pspi_d;
    logic        pspi_we;
    logic        pspi_ready = 1'b0;

    fb_fill_engine #(
        .H_RES   (H),
        .V_RES   (V),
        .FB_BASE (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .done       (done),
        .pspi_a     (pspi_a),
        .pspi_d     (pspi_d),
        .pspi_we    (pspi_we),
        .pspi_ready (pspi_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   we_cnt   = 0;
    bit   in_reset = 1'b1;
    bit   stray    = 1'b0;
    int   fixed_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.a = '0; e.d = '0;
        exp_q.push_back(e);
    endtask

    task automatic model_cmd(input int x, input int y, input int w, input int h, input logic [15:0] c);
        longint x0, x1, y1;
        logic [31:0] d;
        x0 = x - (x % 2);
        x1 = x0 + w + (w % 2);
        y1 = y + h;
`ifdef FB_FILL_CLIP_EN
        if (x1 > H) x1 = H;
        if (y1 > V) y1 = V;
`endif
        d = {c[7:0], c[15:8], c[7:0], c[15:8]};
        for (longint r = y; r < y1; r++)
            for (longint px = x0; px < x1; px += 2)
                push_write(32'(longint'(BASE) + r * H * 2 + px * 2), d);
        push_done();
    endtask

    // ---------------- host model ----------------
    int hcnt = 0;
    always @(posedge clk) begin
        #1;
        pspi_ready = stray;
        stray = 1'b0;
        if (rst || in_reset) begin
            hcnt = 0;
        end else begin
            if (hcnt > 0) begin
                hcnt--;
                if (hcnt == 0) pspi_ready = 1'b1;
            end
            if (pspi_we) hcnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        end
    end

    // ---------------- monitor ----------------
    bit          busy = 1'b0, acc_prev = 1'b0, rdy_prev = 1'b0, done_prev = 1'b0;
    bit          ok;
    exp_t        got;
    logic [31:0] last_a = '0;

    always @(negedge clk) begin
        if (in_reset) begin
            busy = 1'b0; acc_prev = 1'b0; rdy_prev = 1'b0; done_prev = 1'b0;
        end else begin
            if (acc_prev)  check("accept_to_first", {31'd0, pspi_we | done}, 32'd1);
            if (rdy_prev)  check("ready_to_next", {31'd0, pspi_we | done}, 32'd1);
            if (done_prev) check("cmd_ready_after_done", {31'd0, cmd_ready}, 32'd1);
            if (busy)      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            if (pspi_ready && busy) check("hold_addr", pspi_a, last_a);
            if (pspi_we) begin
                we_cnt++;
                ok = (exp_q.size() != 0) && !exp_q[0].is_done;
                check("we_expected", {31'd0, ok}, 32'd1);
                if (ok) begin
                    got = exp_q.pop_front();
                    check("wr_addr", pspi_a, got.a);
                    check("wr_data", pspi_d, got.d);
                end
                last_a = pspi_a;
            end
            if (done) begin
                done_cnt++;
                ok = (exp_q.size() != 0) && exp_q[0].is_done;
                check("done_expected", {31'd0, ok}, 32'd1);
                if (ok) got = exp_q.pop_front();
            end
            acc_prev = cmd_valid && cmd_ready;
            if (acc_prev) busy = 1'b1;
            rdy_prev  = pspi_ready && busy;
            done_prev = done;
            if (done) busy = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int x, input int y, input int w, input int h,
                         input logic [15:0] c, input bit toggle, input bit use_model);
        int start;
        int guard;
        if (use_model) model_cmd(x, y, w, h, c);
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            @(posedge clk); #1; guard++;
        end
        check("idle_before_cmd", {31'd0, cmd_ready}, 32'd1);
        start = done_cnt;
        cmd_x = 16'(x); cmd_y = 16'(y); cmd_w = 16'(w); cmd_h = 16'(h); cmd_color = c;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x = 16'($urandom); cmd_y = 16'($urandom); cmd_w = 16'($urandom);
        cmd_h = 16'($urandom); cmd_color = 16'($urandom);
        guard = 0;
        while (done_cnt == start && guard < 5000) begin
            if (toggle) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_x = 16'($urandom_range(0, 300)); cmd_y = 16'($urandom_range(0, 200));
                cmd_w = 16'($urandom_range(1, 8));   cmd_h = 16'($urandom_range(1, 3));
                cmd_color = 16'($urandom);
            end
            @(posedge clk); #1; guard++;
        end
        cmd_valid = 1'b0;
        check("done_seen", {31'd0, done_cnt != start}, 32'd1);
    endtask

    initial begin
        int we0;
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, pspi_we}, 32'd0);
        check("rst_addr", pspi_a, 32'd0);
        check("rst_data", pspi_d, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        in_reset = 1'b0;

        // Red 4x2 block at (10,5), host latency 3
        fixed_lat = 3;
        push_write(32'd3220, 32'h00F800F8);
        push_write(32'd3224, 32'h00F800F8);
        push_write(32'd3860, 32'h00F800F8);
        push_write(32'd3864, 32'h00F800F8);
        push_done();
        issue(10, 5, 4, 2, RED, 1'b0, 1'b0);

        // Odd x and odd width: x forced to 6, width rounded to 4
        push_write(32'd12, 32'hE0FFE0FF);
        push_write(32'd16, 32'hE0FFE0FF);
        push_done();
        issue(7, 0, 3, 1, YELLOW, 1'b0, 1'b0);

        // Bottom-right corner: clipped to one word, or 50 words unclipped
        fixed_lat = 0;
        issue(318, 239, 10, 10, YELLOW, 1'b0, 1'b1);

        // Empty and off-screen commands
        issue(20, 20, 0, 5, RED, 1'b0, 1'b1);
        issue(20, 20, 6, 0, RED, 1'b0, 1'b1);
        issue(400, 10, 4, 1, BLACK, 1'b0, 1'b1);

        // Stray ready while idle must not start anything
        we0 = we_cnt;
        stray = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stray_ready_idle", {31'd0, cmd_ready}, 32'd1);
        check("stray_ready_no_we", we_cnt, we0);

        // Reset during WAIT of the second word
        fixed_lat = 3;
        push_write(32'd0, 32'h00F800F8);
        push_write(32'd4, 32'h00F800F8);
        we0 = we_cnt;
        cmd_x = 16'd0; cmd_y = 16'd0; cmd_w = 16'd8; cmd_h = 16'd1; cmd_color = RED;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (we_cnt < we0 + 2 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check("second_word_seen", we_cnt, we0 + 2);
        in_reset = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_we", {31'd0, pspi_we}, 32'd0);
        rst = 1'b0;
        check("midrst_queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        in_reset = 1'b0;
        fixed_lat = 0;
        issue(2, 3, 6, 2, YELLOW, 1'b0, 1'b1);

        // cmd_valid toggling mid-command
        issue(100, 50, 8, 3, RED, 1'b1, 1'b1);

        // Randomized commands
        for (int i = 0; i < 24; i++)
            issue(int'($urandom_range(0, 335)), int'($urandom_range(0, 245)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                  16'($urandom), 1'(i % 4 == 3), 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty_at_end", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
